// File: rtl/shared_bus_pkg.sv
// Shared definitions for the gated internal data bus: error FSM states and
// helpers for the float pattern and the source-index width.
package shared_bus_pkg;

    localparam int MAX_W = 64;

    typedef enum logic {S_OK, S_ERR} err_state_e;

    // Alternating 1010... word, LSB aligned so bit 0 is 0 (16'hAAAA at 16 bits).
    function automatic logic [MAX_W-1:0] float_pattern(input int width);
        logic [MAX_W-1:0] p;
        p = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) begin
                p[i] = (i % 2) == 1;
            end
        end
        return p;
    endfunction

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_onehot_dec.sv
// Classifies a gate vector as none / single / multi and reports the index of
// the asserted bit; the index is only meaningful when single is high.
module bus_onehot_dec
    import shared_bus_pkg::*;
#(
    parameter int N_SRC = 5,
    parameter int IW    = idx_w(N_SRC)
) (
    input  logic [N_SRC-1:0] gate,
    output logic             none,
    output logic             single,
    output logic             multi,
    output logic [IW-1:0]    idx
);

    // Clearing the lowest set bit leaves something only if two or more were set.
    always_comb begin
        none   = (gate == '0);
        multi  = |(gate & (gate - N_SRC'(1)));
        single = !none && !multi;
        idx    = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (gate[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/shared_bus_gate.sv
// N-source gated driver for the shared internal data bus, with idle hold or
// float, and a sticky contention detector that records the gate set and counts.
module shared_bus_gate
    import shared_bus_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               N_SRC     = 5,
    parameter int               HOLD_EN   = 1,
    parameter logic [WIDTH-1:0] FLOAT_VAL = WIDTH'(float_pattern(WIDTH)),
    parameter int               CNT_W     = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [N_SRC*WIDTH-1:0]   src_data,
    input  logic [N_SRC-1:0]         gate,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         bus,
    output logic                     bus_valid,
    output logic [idx_w(N_SRC)-1:0]  last_src,
    output logic                     err_flag,
    output logic [N_SRC-1:0]         err_mask,
    output logic [CNT_W-1:0]         err_cnt
);

    localparam int IW = idx_w(N_SRC);

    logic          gate_none;
    logic          gate_single;
    logic          gate_multi;
    logic [IW-1:0] gate_idx;

    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] sel_word;

    err_state_e       state_q, state_d;
    logic [N_SRC-1:0] mask_d;
    logic [CNT_W-1:0] cnt_d;

    bus_onehot_dec #(.N_SRC(N_SRC), .IW(IW)) u_dec (
        .gate   (gate),
        .none   (gate_none),
        .single (gate_single),
        .multi  (gate_multi),
        .idx    (gate_idx)
    );

    assign sel_word = src_data[gate_idx*WIDTH +: WIDTH];

    // Contention always floats; an idle bus either holds or floats by build.
    always_comb begin
        bus       = FLOAT_VAL;
        bus_valid = 1'b0;
        if (gate_single) begin
            bus       = sel_word;
            bus_valid = 1'b1;
        end else if (gate_none && (HOLD_EN != 0)) begin
            bus = hold_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_q   <= '0;
            last_src <= '0;
        end else if (gate_single) begin
            hold_q   <= sel_word;
            last_src <= gate_idx;
        end
    end

    // Contention beats a simultaneous clear and restarts the capture.
    always_comb begin
        state_d = state_q;
        mask_d  = err_mask;
        cnt_d   = err_cnt;
        if (gate_multi) begin
            if (state_q == S_OK || clr_err) begin
                state_d = S_ERR;
                mask_d  = gate;
                cnt_d   = CNT_W'(1);
            end else if (err_cnt != '1) begin
                cnt_d = err_cnt + CNT_W'(1);
            end
        end else if (clr_err) begin
            state_d = S_OK;
            mask_d  = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_OK;
            err_mask <= '0;
            err_cnt  <= '0;
        end else begin
            state_q  <= state_d;
            err_mask <= mask_d;
            err_cnt  <= cnt_d;
        end
    end

    assign err_flag = (state_q == S_ERR);

endmodule

// File: tb/tb_shared_bus_gate.sv
// Directed bench for shared_bus_gate: default build plus HOLD_EN=0 and CNT_W=2
// builds driven in lockstep from the same stimulus.
module tb_shared_bus_gate;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [79:0]  src_data;
    logic [4:0]   gate;
    logic         clr_err;

    logic [15:0]  bus, bus_nh, bus_sat;
    logic         bus_valid, valid_nh, valid_sat;
    logic [2:0]   last_src, last_nh, last_sat;
    logic         err_flag, flag_nh, flag_sat;
    logic [4:0]   err_mask, mask_nh, mask_sat;
    logic [7:0]   err_cnt, cnt_nh;
    logic [1:0]   cnt_sat;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 Clk = ~Clk;

    shared_bus_gate dut (
        .Clk(Clk), .Reset(Reset), .src_data(src_data), .gate(gate), .clr_err(clr_err),
        .bus(bus), .bus_valid(bus_valid), .last_src(last_src), .err_flag(err_flag),
        .err_mask(err_mask), .err_cnt(err_cnt)
    );

    shared_bus_gate #(.HOLD_EN(0)) dut_nh (
        .Clk(Clk), .Reset(Reset), .src_data(src_data), .gate(gate), .clr_err(clr_err),
        .bus(bus_nh), .bus_valid(valid_nh), .last_src(last_nh), .err_flag(flag_nh),
        .err_mask(mask_nh), .err_cnt(cnt_nh)
    );

    shared_bus_gate #(.CNT_W(2)) dut_sat (
        .Clk(Clk), .Reset(Reset), .src_data(src_data), .gate(gate), .clr_err(clr_err),
        .bus(bus_sat), .bus_valid(valid_sat), .last_src(last_sat), .err_flag(flag_sat),
        .err_mask(mask_sat), .err_cnt(cnt_sat)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; combinational checks follow 1ns later.
    task automatic applyStimulus(input logic [4:0] g, input logic clr, input logic rst);
        gate    = g;
        clr_err = clr;
        Reset   = rst;
        #1;
    endtask

    task automatic stepClock();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        src_data = {16'hBEEF, 16'h4444, 16'h1234, 16'h2222, 16'h1111};
        applyStimulus(5'b00000, 1'b0, 1'b1);
        stepClock();
        stepClock();
        checkOutput("rst_flag", 32'(err_flag), 32'd0);
        checkOutput("rst_mask", 32'(err_mask), 32'd0);
        checkOutput("rst_cnt", 32'(err_cnt), 32'd0);
        checkOutput("rst_last", 32'(last_src), 32'd0);
        checkOutput("rst_bus_hold", 32'(bus), 32'h0000);
        checkOutput("rst_bus_float", 32'(bus_nh), 32'hAAAA);

        applyStimulus(5'b00100, 1'b0, 1'b0);
        checkOutput("single_bus", 32'(bus), 32'h1234);
        checkOutput("single_valid", 32'(bus_valid), 32'd1);
        stepClock();
        checkOutput("single_last", 32'(last_src), 32'd2);
        checkOutput("single_flag", 32'(err_flag), 32'd0);

        applyStimulus(5'b10000, 1'b0, 1'b0);
        checkOutput("src4_bus", 32'(bus), 32'hBEEF);
        stepClock();
        applyStimulus(5'b00000, 1'b0, 1'b0);
        checkOutput("idle_hold_bus", 32'(bus), 32'hBEEF);
        checkOutput("idle_valid", 32'(bus_valid), 32'd0);
        checkOutput("idle_float_bus", 32'(bus_nh), 32'hAAAA);
        checkOutput("idle_last", 32'(last_src), 32'd4);

        applyStimulus(5'b10001, 1'b0, 1'b0);
        checkOutput("cont_bus", 32'(bus), 32'hAAAA);
        checkOutput("cont_valid", 32'(bus_valid), 32'd0);
        stepClock();
        checkOutput("cont_flag", 32'(err_flag), 32'd1);
        checkOutput("cont_mask", 32'(err_mask), 32'h11);
        checkOutput("cont_cnt", 32'(err_cnt), 32'd1);
        checkOutput("cont_last", 32'(last_src), 32'd4);
        applyStimulus(5'b00110, 1'b0, 1'b0);
        stepClock();
        stepClock();
        applyStimulus(5'b00000, 1'b0, 1'b0);
        checkOutput("cont2_mask", 32'(err_mask), 32'h11);
        checkOutput("cont2_cnt", 32'(err_cnt), 32'd3);
        checkOutput("cont2_cnt_w2", 32'(cnt_sat), 32'd3);
        checkOutput("cont_hold_kept", 32'(bus), 32'hBEEF);

        applyStimulus(5'b00000, 1'b1, 1'b0);
        stepClock();
        applyStimulus(5'b00000, 1'b0, 1'b0);
        checkOutput("clr_flag", 32'(err_flag), 32'd0);
        checkOutput("clr_mask", 32'(err_mask), 32'd0);
        checkOutput("clr_cnt", 32'(err_cnt), 32'd0);

        applyStimulus(5'b01010, 1'b1, 1'b0);
        stepClock();
        applyStimulus(5'b00000, 1'b0, 1'b0);
        checkOutput("clrmulti_flag", 32'(err_flag), 32'd1);
        checkOutput("clrmulti_mask", 32'(err_mask), 32'h0A);
        checkOutput("clrmulti_cnt", 32'(err_cnt), 32'd1);

        applyStimulus(5'b11111, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) stepClock();
        checkOutput("sat_cnt8", 32'(err_cnt), 32'd6);
        checkOutput("sat_cnt2", 32'(cnt_sat), 32'd3);
        checkOutput("sat_mask", 32'(err_mask), 32'h0A);
        stepClock();
        stepClock();
        checkOutput("sat_cnt2_hold", 32'(cnt_sat), 32'd3);
        checkOutput("sat_cnt8_more", 32'(err_cnt), 32'd8);

        // clr with contention restarts at 1, then one more contention makes 2
        applyStimulus(5'b00011, 1'b1, 1'b0);
        stepClock();
        applyStimulus(5'b00011, 1'b0, 1'b0);
        stepClock();
        checkOutput("pre_rst_cnt", 32'(err_cnt), 32'd2);
        checkOutput("pre_rst_mask", 32'(err_mask), 32'h03);
        applyStimulus(5'b00011, 1'b0, 1'b1);
        checkOutput("rst_cont_bus", 32'(bus), 32'hAAAA);
        stepClock();
        checkOutput("rstmid_flag", 32'(err_flag), 32'd0);
        checkOutput("rstmid_mask", 32'(err_mask), 32'd0);
        checkOutput("rstmid_cnt", 32'(err_cnt), 32'd0);
        checkOutput("rstmid_last", 32'(last_src), 32'd0);
        checkOutput("rstmid_bus", 32'(bus), 32'hAAAA);
        applyStimulus(5'b00000, 1'b0, 1'b0);
        checkOutput("post_rst_hold", 32'(bus), 32'h0000);

        applyStimulus(5'b00010, 1'b0, 1'b0);
        checkOutput("src1_bus", 32'(bus), 32'h2222);
        stepClock();
        applyStimulus(5'b00000, 1'b0, 1'b0);
        checkOutput("src1_last", 32'(last_src), 32'd1);
        checkOutput("src1_hold", 32'(bus), 32'h2222);
        checkOutput("src1_float", 32'(bus_nh), 32'hAAAA);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
